apb_slave_wait_ctrl: RTL and testbench

Parametrised APB3 slave front-end for the watermarking datapath, the registered next generation of the zero-wait write/read decoder. Decodes APB transfers into one-cycle memory strobes and supports programmable wait states and a configurable memory read latency. Drives PREADY and PSLVERR, and rejects out-of-range addresses. Sits between the APB bus and the image/watermark memory ports.

---
 rtl/apb_wait_pkg.sv | 14 +
 rtl/apb_wait_counter.sv | 18 +
 rtl/apb_slave_wait_ctrl.sv | 105 ++++++++++
 tb/tb_apb_slave_wait_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_wait_pkg.sv
// apb_wait_pkg: shared state encoding, counter width and elaboration helpers
package apb_wait_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int CNT_W = clog2(max_of(15, 9) + 1);
endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: loadable down-counter; zero flags the value being written this edge
module apb_wait_counter
  import apb_wait_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : en ? cnt_q - CNT_W'(1) : cnt_q;
  assign zero = cnt_d == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/apb_slave_wait_ctrl.sv
// apb_slave_wait_ctrl: APB3 slave front-end with programmable wait states and memory read latency
module apb_slave_wait_ctrl
  import apb_wait_pkg::*;
#(
  parameter int          amba_addr_depth = 20,
  parameter int          amba_word       = 16,
  parameter int unsigned addr_limit      = 2 ** amba_addr_depth,
  parameter int          wait_states     = 0,
  parameter int          rd_latency      = 1
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [amba_addr_depth-1:0] PADDR,
  input  logic [amba_word-1:0]       PWDATA,
  output logic [amba_word-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic                       Wena,
  output logic                       Rena,
  output logic [amba_addr_depth-1:0] Addr,
  output logic [amba_word-1:0]       Wdata,
  input  logic [amba_word-1:0]       Rdata_in
);
  localparam int AW1 = amba_addr_depth + 1;
  localparam logic [AW1-1:0]   LIMIT   = AW1'(addr_limit);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(wait_states);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(max_of(wait_states, rd_latency + 1));
  localparam logic [CNT_W-1:0] RD_LAT  = CNT_W'(rd_latency);
  state_e                     state_q, state_d;
  logic                       write_q, write_d;
  logic [amba_addr_depth-1:0] addr_q, addr_d;
  logic [amba_word-1:0]       wdata_q, wdata_d, hold_q, hold_d, prdata_q, prdata_d;
  logic [CNT_W-1:0]           acyc_q, acyc_d;
  logic                       pready_q, pready_d, pslverr_q, pslverr_d;
  logic                       wena_q, wena_d, rena_q, rena_d;
  logic                       setup, finish, start, abort, step, err, capture, zero;
  logic [CNT_W-1:0]           load_val;
  assign setup    = PSEL && !PENABLE;
  assign finish   = state_q == ACCESS && pready_q;
  // a setup on the completing edge chains straight into the next access
  assign start    = setup && (state_q == IDLE || finish);
  assign abort    = state_q == ACCESS && !pready_q && !(PSEL && PENABLE);
  assign step     = state_q == ACCESS && !pready_q && !abort;
  assign err      = {1'b0, PADDR} >= LIMIT;
  assign capture  = step && !write_q && acyc_q == RD_LAT;
  assign load_val = err ? '0 : PWRITE ? WR_LOAD : RD_LOAD;
  apb_wait_counter u_cnt (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .load    (start),
    .load_val(load_val),
    .en      (step),
    .zero    (zero)
  );
  always_comb begin
    state_d   = start ? ACCESS : abort ? IDLE : finish ? DONE : state_q == DONE ? IDLE : state_q;
    write_d   = start ? PWRITE : write_q;
    addr_d    = start ? PADDR : addr_q;
    wdata_d   = start ? PWDATA : wdata_q;
    acyc_d    = start ? '0 : state_q == ACCESS ? acyc_q + CNT_W'(1) : acyc_q;
    hold_d    = (start || abort) ? '0 : capture ? Rdata_in : hold_q;
    pready_d  = (start || step) && zero;
    pslverr_d = start && err;
    // when the final access cycle is also the capture cycle, forward the memory data directly
    prdata_d  = (step && zero && !write_q) ? (capture ? Rdata_in : hold_q) : '0;
    wena_d    = start && !err && PWRITE;
    rena_d    = start && !err && !PWRITE;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      acyc_q    <= '0;
      hold_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      wena_q    <= 1'b0;
      rena_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      acyc_q    <= acyc_d;
      hold_q    <= hold_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wena_q    <= wena_d;
      rena_q    <= rena_d;
    end
  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign Wena    = wena_q;
  assign Rena    = rena_q;
  assign Addr    = addr_q;
  assign Wdata   = wdata_q;
endmodule

// File: tb/tb_apb_slave_wait_ctrl.sv
// tb_apb_slave_wait_ctrl: scoreboard bench over three differently parameterised slaves
module tb_apb_slave_wait_ctrl;
  localparam int          WS  [3] = '{0, 3, 5};
  localparam int          RDL [3] = '{1, 4, 1};
  localparam int unsigned LIM [3] = '{1024, 1 << 20, 1 << 20};
  typedef struct {
    bit          w;
    bit          err;
    bit          ab;
    int          lat;
    logic [15:0] rd;
    logic [19:0] a;
    logic [15:0] wd;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [19:0] paddr;
  logic [15:0] pwdata, mem_val;
  logic [2:0]  pready, pslverr, wena, rena;
  logic [15:0] prdata [3];
  logic [15:0] wdata_o [3];
  logic [15:0] rdata_in [3];
  logic [19:0] addr_o [3];
  logic [7:0]  vp [3] = '{default: 8'h00};
  exp_t        q[$];
  int          cur = 0, k = 100, n_strb = 0, n_cmp = 0, n_err = 0;
  logic        setup_seen = 1'b0;
  always #5 clk = ~clk;
  apb_slave_wait_ctrl #(.amba_addr_depth(20), .amba_word(16), .addr_limit(LIM[0]), .wait_states(WS[0]), .rd_latency(RDL[0])) u_a (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .Wena(wena[0]), .Rena(rena[0]), .Addr(addr_o[0]),
    .Wdata(wdata_o[0]), .Rdata_in(rdata_in[0]));
  apb_slave_wait_ctrl #(.amba_addr_depth(20), .amba_word(16), .addr_limit(LIM[1]), .wait_states(WS[1]), .rd_latency(RDL[1])) u_b (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .Wena(wena[1]), .Rena(rena[1]), .Addr(addr_o[1]),
    .Wdata(wdata_o[1]), .Rdata_in(rdata_in[1]));
  apb_slave_wait_ctrl #(.amba_addr_depth(20), .amba_word(16), .addr_limit(LIM[2]), .wait_states(WS[2]), .rd_latency(RDL[2])) u_c (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]), .Wena(wena[2]), .Rena(rena[2]), .Addr(addr_o[2]),
    .Wdata(wdata_o[2]), .Rdata_in(rdata_in[2]));
  // memory model: data is valid only during the cycle rd_latency cycles after the Rena cycle
  always @(posedge clk)
    for (int i = 0; i < 3; i++) vp[i] <= {vp[i][6:0], rena[i]};
  assign rdata_in[0] = vp[0][RDL[0]-1] ? mem_val : 16'hDEAD;
  assign rdata_in[1] = vp[1][RDL[1]-1] ? mem_val : 16'hDEAD;
  assign rdata_in[2] = vp[2][RDL[2]-1] ? mem_val : 16'hDEAD;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic setup(input int i, input bit w, input logic [19:0] a, input logic [15:0] d,
                       input logic [15:0] rv, input bit ab);
    exp_t e;
    cur = i;
    psel = '0;
    psel[i] = 1'b1;
    penable = 1'b0;
    pwrite = w;
    paddr = a;
    pwdata = d;
    mem_val = rv;
    e.w = w;
    e.a = a;
    e.wd = d;
    e.ab = ab;
    e.err = 32'(a) >= LIM[i];
    e.lat = e.err ? 0 : w ? WS[i] : (WS[i] > RDL[i] + 1 ? WS[i] : RDL[i] + 1);
    e.rd = (e.err || w) ? 16'h0 : rv;
    q.push_back(e);
  endtask
  task automatic access();
    @(posedge clk);
    #1 penable = 1'b1;
  endtask
  task automatic wait_ready(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready[i] && n < 40);
    if (!pready[i]) chk("ready_timeout", 64'(pready[i]), 64'(1));
  endtask
  task automatic idle_bus();
    psel = '0;
    penable = 1'b0;
  endtask
  task automatic xfer(input int i, input bit w, input logic [19:0] a, input logic [15:0] d, input logic [15:0] rv);
    @(posedge clk);
    #1 setup(i, w, a, d, rv, 1'b0);
    access();
    wait_ready(i);
    idle_bus();
    repeat (2) @(posedge clk);
  endtask
  initial forever begin
    @(posedge clk);
    setup_seen = psel[cur] && !penable;
  end
  initial forever begin
    exp_t it;
    @(negedge clk);
    k = setup_seen ? 0 : k + 1;
    if (setup_seen) n_strb = 0;
    if (wena[cur] || rena[cur]) begin
      n_strb++;
      chk("strobe_both", 64'(wena[cur] & rena[cur]), 64'(0));
      chk("strobe_cycle", 64'(k), 64'(0));
      if (q.size() > 0) begin
        chk("strobe_dir", 64'(wena[cur]), 64'(q[0].w));
        chk("addr", 64'(addr_o[cur]), 64'(q[0].a));
        if (wena[cur]) chk("wdata", 64'(wdata_o[cur]), 64'(q[0].wd));
      end else chk("stray_strobe", 64'(n_strb), 64'(0));
    end
    if (pready[cur]) begin
      if (q.size() == 0) chk("unexpected_pready", 64'(pready[cur]), 64'(0));
      else begin
        it = q.pop_front();
        if (it.ab) chk("aborted_pready", 64'(pready[cur]), 64'(0));
        else begin
          chk("latency", 64'(k), 64'(it.lat));
          chk("pslverr", 64'(pslverr[cur]), 64'(it.err));
          chk("prdata", 64'(prdata[cur]), 64'(it.rd));
          chk("strobes", 64'(n_strb), 64'(!it.err));
        end
      end
    end else chk("idle_zero", 64'({pslverr[cur], prdata[cur]}), 64'(0));
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    psel = '0;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    mem_val = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_ctl", 64'({pready[i], pslverr[i], wena[i], rena[i]}), 64'(0));
      chk("reset_data", 64'({prdata[i], addr_o[i], wdata_o[i]}), 64'(0));
    end
    rst_n = 1'b1;
    xfer(0, 1'b1, 20'h00010, 16'hBEEF, 16'h0);
    xfer(0, 1'b0, 20'h00020, 16'h0, 16'h1234);
    xfer(0, 1'b0, 20'd1024, 16'h0, 16'h9999);
    xfer(0, 1'b0, 20'd1023, 16'h0, 16'h0F0F);
    xfer(0, 1'b1, 20'd1024, 16'h5A5A, 16'h0);
    @(posedge clk);
    #1 setup(0, 1'b1, 20'h00030, 16'hCAFE, 16'h0, 1'b0);
    access();
    wait_ready(0);
    setup(0, 1'b0, 20'h00031, 16'h0, 16'h4321, 1'b0);
    access();
    wait_ready(0);
    idle_bus();
    repeat (2) @(posedge clk);
    xfer(1, 1'b1, 20'h00100, 16'hAAAA, 16'h0);
    xfer(1, 1'b0, 20'h00200, 16'h0, 16'h5555);
    @(posedge clk);
    #1 setup(1, 1'b0, 20'h00400, 16'h0, 16'h7777, 1'b1);
    access();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    idle_bus();
    repeat (10) @(posedge clk);
    chk("abort_pending", 64'(q.size()), 64'(1));
    if (q.size() > 0) void'(q.pop_front());
    xfer(1, 1'b1, 20'h00300, 16'h0F0F, 16'h0);
    @(posedge clk);
    #1 setup(1, 1'b0, 20'h00500, 16'h0, 16'h3C3C, 1'b0);
    access();
    wait_ready(1);
    setup(1, 1'b1, 20'h00501, 16'hD00D, 16'h0, 1'b0);
    access();
    wait_ready(1);
    idle_bus();
    repeat (2) @(posedge clk);
    xfer(2, 1'b0, 20'hFFFFF, 16'h0, 16'h8001);
    @(posedge clk);
    #1 setup(2, 1'b1, 20'h0ABCD, 16'h1357, 16'h0, 1'b1);
    access();
    @(posedge clk);
    #3 rst_n = 1'b0;
    idle_bus();
    #1;
    chk("rst_mid_ctl", 64'({pready[2], pslverr[2], wena[2], rena[2]}), 64'(0));
    chk("rst_mid_data", 64'({prdata[2], addr_o[2], wdata_o[2]}), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("reset_pending", 64'(q.size()), 64'(1));
    if (q.size() > 0) void'(q.pop_front());
    xfer(2, 1'b1, 20'h0ABCE, 16'h2468, 16'h0);
    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
